// File: rtl/rs_pkg.sv
// Shared definitions for the ALU reservation-station issue logic.
`timescale 1ns/1ps
package rs_pkg;

    localparam int N_ENT    = 8;
    localparam int CONF_CYC = 2;
    localparam int DLY_LEN  = 2;  // width of the per-entry confirmation counter

    typedef enum logic [1:0] {
        ENT_FREE   = 2'd0,
        ENT_WAIT   = 2'd1,
        ENT_ISSUED = 2'd2
    } ent_state_t;

endpackage

// File: rtl/age_matrix.sv
// Relative-age tracker: older[i][j]=1 means entry j was allocated before entry i.
`timescale 1ns/1ps
module age_matrix #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [N-1:0] alloc_oh,
    input  logic [N-1:0] busy,
    input  logic [N-1:0] elig,
    output logic [N-1:0] oldest_oh,
    output logic [N-1:0] second_oh
);

    logic [N-1:0] older [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else begin
            // New entry sees every live entry as older; its column is wiped so stale
            // bits from a previous occupant never make it look old to others.
            for (int i = 0; i < N; i++) begin
                if (alloc_oh[i])
                    older[i] <= busy & ~alloc_oh;
                else
                    older[i] <= older[i] & ~alloc_oh;
            end
        end
    end

    always_comb begin
        oldest_oh = '0;
        second_oh = '0;
        for (int i = 0; i < N; i++) begin
            oldest_oh[i] = elig[i] && ((older[i] & elig) == '0);
            second_oh[i] = elig[i] && ($countones(older[i] & elig) == 1);
        end
    end

endmodule

// File: rtl/issue_select.sv
// Dual-port oldest-first issue select for the ALU reservation station.
`timescale 1ns/1ps
module issue_select
    import rs_pkg::*;
#(
    parameter int N_ENT    = rs_pkg::N_ENT,
    parameter int CONF_CYC = rs_pkg::CONF_CYC,
    localparam int IDX_W   = (N_ENT > 1) ? $clog2(N_ENT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic [N_ENT-1:0] req_vec,
    input  logic [1:0]       fu_rdy,
    output logic [1:0]       gnt_valid,
    output logic [IDX_W-1:0] gnt_idx0,
    output logic [IDX_W-1:0] gnt_idx1,
    input  logic [N_ENT-1:0] cancel_vec,
    input  logic             flush,
    output logic [N_ENT-1:0] busy,
    output logic [N_ENT-1:0] issued
);

    function automatic logic [N_ENT-1:0] lowest_oh(input logic [N_ENT-1:0] v);
        logic [N_ENT-1:0] r;
        r = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] oh2idx(input logic [N_ENT-1:0] oh);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_ENT; i++)
            if (oh[i]) r = r | IDX_W'(i);
        return r;
    endfunction

    ent_state_t       state [N_ENT];
    logic [DLY_LEN-1:0] cnt [N_ENT];

    logic [N_ENT-1:0] free_vec, wait_vec, issued_vec;
    logic [N_ENT-1:0] free_oh, alloc_oh;
    logic [N_ENT-1:0] elig_p0, oldest_p0, second_p0;
    logic [N_ENT-1:0] g0_oh_p0, g1_oh_p0, issue_oh_p0;

    always_comb begin
        free_vec   = '0;
        wait_vec   = '0;
        issued_vec = '0;
        for (int i = 0; i < N_ENT; i++) begin
            free_vec[i]   = (state[i] == ENT_FREE);
            wait_vec[i]   = (state[i] == ENT_WAIT);
            issued_vec[i] = (state[i] == ENT_ISSUED);
        end
    end

    assign busy        = ~free_vec;
    assign issued      = issued_vec;
    assign alloc_ready = |free_vec;
    assign free_oh     = lowest_oh(free_vec);
    assign alloc_idx   = oh2idx(free_oh);
    assign alloc_oh    = free_oh & {N_ENT{alloc_valid & ~flush}};

    // Stage p0: selection from registered state; cancelled entries sit out this cycle.
    assign elig_p0 = req_vec & wait_vec & ~cancel_vec;

    age_matrix #(.N(N_ENT)) u_age (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .alloc_oh  (alloc_oh),
        .busy      (busy),
        .elig      (elig_p0),
        .oldest_oh (oldest_p0),
        .second_oh (second_p0)
    );

    always_comb begin
        g0_oh_p0 = '0;
        g1_oh_p0 = '0;
        if (fu_rdy[0]) begin
            g0_oh_p0 = oldest_p0;
            if (fu_rdy[1]) g1_oh_p0 = second_p0;
        end else if (fu_rdy[1]) begin
            g1_oh_p0 = oldest_p0;
        end
        if (flush) begin
            g0_oh_p0 = '0;
            g1_oh_p0 = '0;
        end
    end

    assign issue_oh_p0 = g0_oh_p0 | g1_oh_p0;

    // Stage p1: registered grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_valid <= '0;
            gnt_idx0  <= '0;
            gnt_idx1  <= '0;
        end else begin
            gnt_valid <= {|g1_oh_p0, |g0_oh_p0};
            if (|g0_oh_p0) gnt_idx0 <= oh2idx(g0_oh_p0);
            if (|g1_oh_p0) gnt_idx1 <= oh2idx(g1_oh_p0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                state[i] <= ENT_FREE;
                cnt[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < N_ENT; i++) begin
                state[i] <= ENT_FREE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                case (state[i])
                    ENT_FREE: begin
                        if (alloc_oh[i]) state[i] <= ENT_WAIT;
                    end
                    ENT_WAIT: begin
                        if (issue_oh_p0[i]) begin
                            state[i] <= ENT_ISSUED;
                            cnt[i]   <= DLY_LEN'(CONF_CYC);
                        end
                    end
                    ENT_ISSUED: begin
                        // Replay beats the free that would otherwise land this cycle.
                        if (cancel_vec[i]) begin
                            state[i] <= ENT_WAIT;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == DLY_LEN'(1) || cnt[i] == '0) begin
                            state[i] <= ENT_FREE;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i] <= cnt[i] - 1'b1;
                        end
                    end
                    default: begin
                        state[i] <= ENT_FREE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_issue_select.sv
// Scoreboard bench for issue_select: expected grants queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_issue_select;

    logic       clk;
    logic       rst_n;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [2:0] alloc_idx;
    logic [7:0] req_vec;
    logic [1:0] fu_rdy;
    logic [1:0] gnt_valid;
    logic [2:0] gnt_idx0;
    logic [2:0] gnt_idx1;
    logic [7:0] cancel_vec;
    logic       flush;
    logic [7:0] busy;
    logic [7:0] issued;

    typedef struct packed {
        logic [1:0] v;
        logic [2:0] i0;
        logic [2:0] i1;
    } gnt_t;

    gnt_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    issue_select dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_idx   (alloc_idx),
        .req_vec     (req_vec),
        .fu_rdy      (fu_rdy),
        .gnt_valid   (gnt_valid),
        .gnt_idx0    (gnt_idx0),
        .gnt_idx1    (gnt_idx1),
        .cancel_vec  (cancel_vec),
        .flush       (flush),
        .busy        (busy),
        .issued      (issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_gnt(input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1);
        gnt_t g;
        g = {v, i0, i1};
        exp_q.push_back(g);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1'b1;
        repeat (n) step();
        alloc_valid = 1'b0;
    endtask

    // Monitor: every presented grant must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && gnt_valid != 2'b00) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_grant: got v=%b i0=%0d i1=%0d, expected none",
                         gnt_valid, gnt_idx0, gnt_idx1);
            end else begin
                gnt_t e;
                e = exp_q.pop_front();
                if (gnt_valid !== e.v ||
                    (e.v[0] && gnt_idx0 !== e.i0) ||
                    (e.v[1] && gnt_idx1 !== e.i1)) begin
                    n_err++;
                    $display("FAIL grant: got v=%b i0=%0d i1=%0d, expected v=%b i0=%0d i1=%0d",
                             gnt_valid, gnt_idx0, gnt_idx1, e.v, e.i0, e.i1);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        req_vec     = '0;
        fu_rdy      = '0;
        cancel_vec  = '0;
        flush       = 1'b0;
        #12;
        chk("rst_busy",        32'(busy),        32'h0);
        chk("rst_issued",      32'(issued),      32'h0);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'h1);
        chk("rst_alloc_idx",   32'(alloc_idx),   32'h0);
        chk("rst_gnt_valid",   32'(gnt_valid),   32'h0);
        chk("rst_gnt_idx0",    32'(gnt_idx0),    32'h0);
        chk("rst_gnt_idx1",    32'(gnt_idx1),    32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Four in-order entries, two ALUs ready: pairs (0,1) then (2,3)
        alloc_n(4);
        chk("a_busy",      32'(busy),      32'h0F);
        chk("a_alloc_idx", 32'(alloc_idx), 32'h4);
        req_vec = 8'h0F;
        fu_rdy  = 2'b11;
        expect_gnt(2'b11, 3'd0, 3'd1);
        expect_gnt(2'b11, 3'd2, 3'd3);
        step();
        step();
        req_vec = '0;
        step();
        chk("a_hold_valid", 32'(gnt_valid), 32'h0);
        chk("a_hold_idx0",  32'(gnt_idx0),  32'h2);
        chk("a_hold_idx1",  32'(gnt_idx1),  32'h3);
        chk("a_busy_conf",  32'(busy),      32'h0C);
        chk("a_issued",     32'(issued),    32'h0C);
        do_flush();

        // Entry 2 recycled after 5: 5 must win despite the higher index
        alloc_n(6);
        req_vec = 8'h04;
        fu_rdy  = 2'b01;
        expect_gnt(2'b01, 3'd2, 3'd0);
        step();
        req_vec = '0;
        step();
        step();
        chk("b_busy",      32'(busy),      32'h3B);
        chk("b_alloc_idx", 32'(alloc_idx), 32'h2);
        alloc_n(1);
        req_vec = 8'h24;
        expect_gnt(2'b01, 3'd5, 3'd0);
        expect_gnt(2'b01, 3'd2, 3'd0);
        step();
        step();
        req_vec = '0;
        do_flush();

        // Confirmation window, then cancel/replay of entry 3
        alloc_n(5);
        req_vec = 8'h08;
        fu_rdy  = 2'b11;
        expect_gnt(2'b01, 3'd3, 3'd0);
        step();
        req_vec = '0;
        chk("c_issued_t1", 32'(issued), 32'h08);
        step();
        chk("c_busy_t2",   32'(busy),   32'h1F);
        step();
        chk("c_busy_t3",   32'(busy),   32'h17);
        chk("c_issued_t3", 32'(issued), 32'h00);
        do_flush();
        alloc_n(5);
        req_vec = 8'h08;
        fu_rdy  = 2'b01;
        expect_gnt(2'b01, 3'd3, 3'd0);
        step();
        req_vec = '0;
        step();
        cancel_vec = 8'h08;
        step();
        cancel_vec = '0;
        chk("c_cancel_issued", 32'(issued), 32'h00);
        chk("c_cancel_busy",   32'(busy),   32'h1F);
        req_vec = 8'h18;
        expect_gnt(2'b01, 3'd3, 3'd0);
        expect_gnt(2'b01, 3'd4, 3'd0);
        step();
        step();
        req_vec = '0;
        do_flush();

        // Full station, ignored alloc, free entry 6, port1-only grants
        alloc_n(8);
        chk("d_full_ready", 32'(alloc_ready), 32'h0);
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        chk("d_full_busy",  32'(busy),        32'hFF);
        req_vec = 8'h40;
        fu_rdy  = 2'b01;
        expect_gnt(2'b01, 3'd6, 3'd0);
        step();
        req_vec = '0;
        step();
        chk("d_ready_t2", 32'(alloc_ready), 32'h0);
        step();
        chk("d_ready_t3", 32'(alloc_ready), 32'h1);
        chk("d_idx_t3",   32'(alloc_idx),   32'h6);
        req_vec = 8'h81;
        fu_rdy  = 2'b10;
        expect_gnt(2'b10, 3'd0, 3'd0);
        expect_gnt(2'b10, 3'd0, 3'd7);
        step();
        step();
        req_vec = '0;
        do_flush();

        // Flush overrides pending grants and a same-cycle allocation
        alloc_n(4);
        req_vec     = 8'h0F;
        fu_rdy      = 2'b11;
        alloc_valid = 1'b1;
        flush       = 1'b1;
        step();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        req_vec     = '0;
        chk("e_gnt_valid",   32'(gnt_valid),   32'h0);
        chk("e_busy",        32'(busy),        32'h0);
        chk("e_alloc_idx",   32'(alloc_idx),   32'h0);
        chk("e_alloc_ready", 32'(alloc_ready), 32'h1);

        // Asynchronous reset while a grant is on the outputs
        alloc_n(2);
        req_vec = 8'h03;
        fu_rdy  = 2'b11;
        expect_gnt(2'b11, 3'd0, 3'd1);
        step();
        req_vec = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("f_gnt_valid",   32'(gnt_valid),   32'h0);
        chk("f_gnt_idx0",    32'(gnt_idx0),    32'h0);
        chk("f_gnt_idx1",    32'(gnt_idx1),    32'h0);
        chk("f_busy",        32'(busy),        32'h0);
        chk("f_issued",      32'(issued),      32'h0);
        chk("f_alloc_ready", 32'(alloc_ready), 32'h1);
        chk("f_alloc_idx",   32'(alloc_idx),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        chk("pending_grants", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 SHALL have parameter N_ENT, default 8, number of ALU reservation-station entries.
REQ-002 SHALL have parameter CONF_CYC, default 2, cycles an issued entry waits before it is freed.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port alloc_valid, input, 1, dispatch requests one entry this cycle.
REQ-006 SHALL have port alloc_ready, output, 1, at least one entry is FREE.
REQ-007 SHALL have port alloc_idx, output, 3, lowest-numbered FREE entry; valid when alloc_ready=1.
REQ-008 SHALL have port req_vec, input, N_ENT, per-entry operands-ready request from wake-up logic.
REQ-009 SHALL have port fu_rdy, input, 2, bit0 = alu1 accepts, bit1 = alu2 accepts.
REQ-010 SHALL have port gnt_valid, output, 2, grant per ALU port, registered.
REQ-011 SHALL have port gnt_idx0 / gnt_idx1, output, 3 each, granted entry for alu1 / alu2.
REQ-012 SHALL have port cancel_vec, input, N_ENT, speculative-issue cancel (replay) per entry.
REQ-013 SHALL have port flush, input, 1, discard all entries.
REQ-014 SHALL have port busy, output, N_ENT, entry not FREE.
REQ-015 SHALL have port issued, output, N_ENT, entry in ISSUED state.

Function
REQ-016 Per-entry state SHALL be FREE, WAIT, or ISSUED, plus a 2-bit confirmation counter.
REQ-017 FREE->WAIT SHALL occur when alloc_valid && alloc_ready, on entry alloc_idx; the entry becomes the youngest in age order.
REQ-018 Eligible set = req_vec & WAIT state; cancel-hit entries SHALL be excluded that cycle.
REQ-019 Port 0 SHALL grant the oldest eligible entry and port 1 the second-oldest; age SHALL be tracked by an N_ENTxN_ENT age matrix.
REQ-020 Port 0 SHALL grant only if fu_rdy[0]=1; when fu_rdy[0]=0, port 1 SHALL take the oldest eligible entry if fu_rdy[1]=1.
REQ-021 Grants SHALL be registered: selection in cycle t gives gnt_valid/gnt_idx in t+1, and the entry is ISSUED from t+1 with counter = CONF_CYC.
REQ-022 An ISSUED entry SHALL decrement its counter each cycle and go ISSUED->FREE when the counter reaches 0 (CONF_CYC cycles after issue).
REQ-023 cancel_vec[i]=1 on an ISSUED entry SHALL return it to WAIT with its age preserved; cancel SHALL win over same-cycle freeing.
REQ-024 An entry freed in cycle t SHALL NOT be allocatable until t+1 (alloc_idx uses registered state).
REQ-025 Both ports SHALL never grant the same entry.
REQ-026 When no entry is eligible, gnt_valid SHALL be 0 and gnt_idx SHALL hold its previous value.
REQ-027 flush SHALL move all entries to FREE, clear the age matrix, and zero gnt_valid next cycle; flush SHALL override alloc, grant, and cancel.
REQ-028 alloc_valid when alloc_ready=0 SHALL be ignored.

Reset
REQ-029 While rst_n=0: all entries FREE, age matrix 0, counters 0, gnt_valid=0, gnt_idx0=gnt_idx1=0, busy=0, issued=0, alloc_ready=1, alloc_idx=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight grants immediately without waiting for a clock edge.

Structure
REQ-031 N_ENT, CONF_CYC, DLY_LEN, and the entry-state enumeration SHALL live in shared package rs_pkg.
REQ-032 Age tracking SHALL be a sub-module age_matrix (set-row-on-alloc, oldest/second-oldest one-hot outputs).

Verification
REQ-033 Allocate entries 0..3 in order, req_vec=8'h0F, fu_rdy=2'b11 -> next cycle gnt_idx0=0, gnt_idx1=1, gnt_valid=2'b11; following cycle grants 2, 3.
REQ-034 Allocate 5 then 2, req_vec=8'h24, fu_rdy=2'b01 -> gnt_idx0=5 only; entry 2 granted next cycle.
REQ-035 Issue entry 3 with CONF_CYC=2 and no cancel -> busy[3] drops exactly 2 cycles after gnt_valid; cancel_vec[3] one cycle after grant -> issued[3]=0, busy[3]=1, entry re-granted before younger entries.
REQ-036 Fill all 8 entries -> alloc_ready=0 and alloc_valid ignored; free entry 6 -> alloc_ready=1, alloc_idx=6 next cycle.
REQ-037 Assert flush while 2 grants are pending and alloc_valid=1 -> busy=0, gnt_valid=0, alloc_idx=0 next cycle.
REQ-038 Drop rst_n asynchronously mid-grant -> all outputs reach their reset values before the next clk edge.
